// File: rtl/apb_uart_rb_pkg.sv
// Shared types and constants for the APB initiator that drives the UART register block.
package apb_uart_rb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Word transfers only: any set bit in the two byte-lane bits is a bad address.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/apb_uart_rb_apb_wdog.sv
// Saturating 8-bit wait-state counter; flags when the ACCESS phase has waited TIMEOUT-1 cycles.
module apb_uart_rb_apb_wdog
  import apb_uart_rb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins, increment stops at all-ones so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count seen here is the number of low-pready cycles before the current one.
  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/apb_uart_rb_apb_master.sv
// APB3 initiator: one valid/ready command in, one APB transfer out, one valid/ready response back.
module apb_uart_rb_apb_master
  import apb_uart_rb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic              apb_pready,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pslverr
);

  apb_mst_state_e state_q, state_d;
  apb_cmd_t       hold_q, hold_d;
  apb_rsp_t       rsp_q, rsp_d;

  logic wd_clear_s;
  logic wd_inc_s;
  logic wd_expired_s;

  apb_uart_rb_apb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (wd_clear_s),
    .inc_i     (wd_inc_s),
    .expired_o (wd_expired_s)
  );

  // Next-state, holding-register and response decisions for the transfer sequence.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rsp_d      = rsp_q;
    wd_clear_s = 1'b0;
    wd_inc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (addr_misaligned(cmd_addr[1:0])) begin
            // Rejected before the bus: the APB lines keep the previous transfer's values.
            rsp_d.rdata   = '0;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b0;
            state_d       = RESP;
          end else begin
            hold_d.write = cmd_write;
            hold_d.addr  = cmd_addr;
            hold_d.wdata = cmd_wdata;
            state_d      = SETUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        wd_clear_s = 1'b1;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (apb_pready) begin
          // A ready slave beats the timeout even on the final allowed cycle.
          rsp_d.rdata   = (hold_q.write || apb_pslverr) ? '0 : apb_prdata;
          rsp_d.err     = apb_pslverr;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (wd_expired_s) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = RESP;
        end else begin
          wd_inc_s = 1'b1;
          state_d  = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rsp_q   <= rsp_d;
    end
  end

  // Handshake and strobe outputs decode the state register; data outputs come from registers.
  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_penable = (state_q == ACCESS);
  assign apb_paddr   = hold_q.addr;
  assign apb_pwrite  = hold_q.write;
  assign apb_pwdata  = hold_q.wdata;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_uart_rb_apb_master.sv
// Directed bench for the APB initiator: a reactive APB slave, a transaction-level
// timeline model checked every cycle, and literal expectations per scenario.
module tb_apb_uart_rb_apb_master;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [11:0] apb_paddr;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_pwdata;
  logic        apb_pready  = 1'b0;
  logic [31:0] apb_prdata  = 32'hDEAD_BEEF;
  logic        apb_pslverr = 1'b1;

  int checks = 0;
  int errors = 0;

  apb_uart_rb_apb_master #(
    .ADDR_W (12), .DATA_W (32), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .reset (reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
    .apb_paddr (apb_paddr), .apb_psel (apb_psel), .apb_penable (apb_penable),
    .apb_pwrite (apb_pwrite), .apb_pwdata (apb_pwdata),
    .apb_pready (apb_pready), .apb_prdata (apb_prdata), .apb_pslverr (apb_pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour: ready after slv_wait wait states; junk data/error while not ready.
  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_seen  = 0;

  always @(negedge clk) begin
    if (apb_psel && apb_penable) begin
      acc_seen    = acc_seen + 1;
      apb_pready  = (acc_seen == slv_wait + 1);
      apb_prdata  = apb_pready ? slv_rdata : 32'hDEAD_BEEF;
      apb_pslverr = apb_pready ? slv_err : 1'b1;
    end else begin
      acc_seen    = 0;
      apb_pready  = 1'b0;
      apb_prdata  = 32'hDEAD_BEEF;
      apb_pslverr = 1'b1;
    end
  end

  // Transaction model: on each accepted command, plan the cycle timeline
  // (1 = setup, 2 = access) and the response; RESP then lasts until rsp_ready.
  int          plan_q[$];
  bit          rsp_pend = 1'b0;
  logic [31:0] m_rdata;
  logic        m_err, m_to, m_write;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;

  always @(negedge clk) begin : cmp
    int ph;
    int n;
    if (reset) begin
      plan_q.delete();
      rsp_pend = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_psel", apb_psel, 0);
      chk("rst_penable", apb_penable, 0);
      chk("rst_rsp_bits", {rsp_rdata, rsp_err, rsp_timeout} == 34'd0, 1);
      chk("rst_apb_bus", {apb_paddr, apb_pwrite, apb_pwdata} == 45'd0, 1);
    end else begin
      if (plan_q.size() > 0) ph = plan_q.pop_front();
      else if (rsp_pend)     ph = 3;
      else                   ph = 0;
      chk("cmd_ready", cmd_ready, (ph == 0));
      chk("rsp_valid", rsp_valid, (ph == 3));
      chk("psel", apb_psel, (ph == 1 || ph == 2));
      chk("penable", apb_penable, (ph == 2));
      if (ph == 1 || ph == 2) begin
        chk("paddr", apb_paddr, m_addr);
        chk("pwrite", apb_pwrite, m_write);
        chk("pwdata", apb_pwdata, m_wdata);
      end
      if (ph == 3) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_timeout", rsp_timeout, m_to);
        if (rsp_ready) rsp_pend = 1'b0;
      end
      if (ph == 0 && cmd_valid) begin
        rsp_pend = 1'b1;
        if (cmd_addr[1:0] != 2'b00) begin
          m_rdata = 32'h0; m_err = 1'b1; m_to = 1'b0;
        end else begin
          m_addr = cmd_addr; m_write = cmd_write; m_wdata = cmd_wdata;
          if (slv_wait >= TIMEOUT) begin
            n = TIMEOUT; m_rdata = 32'h0; m_err = 1'b1; m_to = 1'b1;
          end else begin
            n = slv_wait + 1; m_err = slv_err; m_to = 1'b0;
            m_rdata = (cmd_write || slv_err) ? 32'h0 : slv_rdata;
          end
          plan_q.push_back(1);
          for (int k = 0; k < n; k++) plan_q.push_back(2);
        end
      end
    end
  end

  // Measurement counters for the literal per-scenario expectations.
  int cyc_n = 0, psel_cnt = 0, pen_cnt = 0, last_hs = 0, last_rv = 0;
  int hs_list[$];
  bit rv_prev = 1'b0;

  always @(negedge clk) begin
    cyc_n++;
    if (apb_psel)    psel_cnt++;
    if (apb_penable) pen_cnt++;
    if (cmd_valid && cmd_ready) begin
      last_hs = cyc_n;
      hs_list.push_back(cyc_n);
    end
    if (rsp_valid && !rv_prev) last_rv = cyc_n;
    rv_prev = rsp_valid;
  end

  logic [31:0] got_rdata;
  logic        got_err, got_to;

  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_handshake", ok, 1);
  endtask

  // Waits for the response, then keeps rsp_ready low for 'hold' RESP cycles.
  task automatic wait_rsp(input int hold);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("rsp_arrival", ok, 1);
    got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
    chk("resp_psel_low", apb_psel, 0);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, got_rdata);
      chk("bp_rsp_err", rsp_err, got_err);
      chk("bp_rsp_timeout", rsp_timeout, got_to);
      chk("bp_psel_low", apb_psel, 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic start_mon();
    psel_cnt = 0; pen_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0;
    cmd_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Zero-wait write
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0000_00AA;
    start_mon();
    issue(1'b1, 12'h00C, 32'h0000_0083);
    wait_rsp(0);
    chk("zw_psel_cycles", psel_cnt, 2);
    chk("zw_penable_cycles", pen_cnt, 1);
    chk("zw_latency", last_rv - last_hs, 3);
    chk("zw_err", got_err, 0);
    chk("zw_rdata", got_rdata, 32'h0);

    // Read with three wait states
    slv_wait = 3; slv_rdata = 32'h0000_0060;
    start_mon();
    issue(1'b0, 12'h014, 32'h0);
    wait_rsp(0);
    chk("ws_access_cycles", pen_cnt, 4);
    chk("ws_latency", last_rv - last_hs, 6);
    chk("ws_rdata", got_rdata, 32'h0000_0060);
    chk("ws_err", got_err, 0);

    // Slave error with response back-pressure
    slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h1234_5678; rsp_ready = 1'b0;
    start_mon();
    issue(1'b0, 12'h3FC, 32'h0);
    wait_rsp(5);
    chk("se_err", got_err, 1);
    chk("se_timeout", got_to, 0);
    chk("se_rdata", got_rdata, 32'h0);
    chk("se_psel_cycles", psel_cnt, 2);
    slv_err = 1'b0;

    // Timeout: pready never rises
    slv_wait = 100;
    start_mon();
    issue(1'b0, 12'h018, 32'h0);
    wait_rsp(0);
    chk("to_access_cycles", pen_cnt, 16);
    chk("to_err", got_err, 1);
    chk("to_timeout", got_to, 1);
    chk("to_rdata", got_rdata, 32'h0);

    // Timeout boundary: pready on exactly the 16th ACCESS cycle
    slv_wait = 15; slv_rdata = 32'hCAFE_0016;
    start_mon();
    issue(1'b0, 12'h010, 32'h0);
    wait_rsp(0);
    chk("tb_access_cycles", pen_cnt, 16);
    chk("tb_err", got_err, 0);
    chk("tb_timeout", got_to, 0);
    chk("tb_rdata", got_rdata, 32'hCAFE_0016);

    // Misaligned write
    slv_wait = 0;
    start_mon();
    issue(1'b1, 12'h006, 32'h5555_AAAA);
    wait_rsp(0);
    chk("ma_psel_cycles", psel_cnt, 0);
    chk("ma_latency", last_rv - last_hs, 1);
    chk("ma_err", got_err, 1);
    chk("ma_timeout", got_to, 0);

    // Reset during ACCESS
    slv_wait = 100;
    issue(1'b0, 12'h020, 32'h0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = apb_penable;
      end
      chk("mr_reached_access", seen, 1);
    end
    #2 reset = 1'b1;
    #1;
    chk("mr_psel_drop", apb_psel, 0);
    chk("mr_penable_drop", apb_penable, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back reads
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0000_0042; rsp_ready = 1'b1;
    hs_list.delete();
    for (int k = 0; k < 4; k++) issue(1'b0, 12'(12'h100 + 4 * k), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_count", hs_list.size(), 4);
    if (hs_list.size() == 4) begin
      for (int k = 1; k < 4; k++) chk("b2b_period", hs_list[k] - hs_list[k-1], 4);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
